// File: rtl/synapse_array_seq_if.sv
// Signal bundle for synapse_array_seq: update handshake, weight write port and neuron vectors.
// master drives requests and weights; slave is the synapse array itself.
interface synapse_array_seq_if #(
    parameter int N  = 15,
    parameter int WW = 2
);
    localparam int AW = $clog2(N);

    logic          start;
    logic [N-1:0]  nout;
    logic          w_we;
    logic [AW-1:0] w_row;
    logic [AW-1:0] w_col;
    logic [WW-1:0] w_data;
    logic [N-1:0]  nin;
    logic          busy;
    logic          done;
    logic          wr_rej;

    modport master (
        output start, nout, w_we, w_row, w_col, w_data,
        input  nin, busy, done, wr_rej
    );

    modport slave (
        input  start, nout, w_we, w_row, w_col, w_data,
        output nin, busy, done, wr_rej
    );
endinterface

// File: rtl/synapse_array_seq.sv
// Sequential Hopfield-style synapse array: one weight row per cycle against a captured nout snapshot.
// Define SYN_TIE_HOLD_EN to make a tied row keep its current nin bit instead of resolving to 0.
//
// state | meaning
// IDLE  | waiting for start; weight writes accepted
// RUN   | evaluating row cnt_q into the shadow vector
// DONE  | loading shadow into nin and pulsing done
module synapse_array_seq #(
    parameter int N  = 15,
    parameter int WW = 2
) (
    input logic               clk,
    input logic               rst_n,
    synapse_array_seq_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam int SW = $clog2(N * ((1 << WW) - 1) + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                         state_q, state_d;
    logic [N-1:0][N-1:0][WW-1:0]    w_q;
    logic [N-1:0]                   snap_q;
    logic [N-1:0]                   shadow_q;
    logic [N-1:0]                   nin_q;
    logic [AW-1:0]                  cnt_q;
    logic                           done_q;
    logic                           wr_rej_q;

    logic                           snap_ld;
    logic                           row_en;
    logic                           nin_ld;
    logic                           last_row;
    logic                           addr_ok;
    logic                           wr_ok;
    logic                           wr_bad;
    logic [SW-1:0]                  sum1;
    logic [SW-1:0]                  sum0;
    logic                           row_bit;

    assign last_row = (cnt_q == AW'(N - 1));
    assign addr_ok  = (int'(bus.w_row) < N) && (int'(bus.w_col) < N);
    assign wr_ok    = bus.w_we && (state_q == IDLE) && addr_ok;
    assign wr_bad   = bus.w_we && !wr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_ld = 1'b0;
        row_en  = 1'b0;
        nin_ld  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    snap_ld = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                row_en = 1'b1;
                if (last_row) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                nin_ld  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A write sampled on the same edge as start commits before row 0 is read one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
        end else if (wr_ok) begin
            w_q[bus.w_row][bus.w_col] <= bus.w_data;
        end
    end

    always_comb begin
        sum1 = '0;
        sum0 = '0;
        for (int l = 0; l < N; l++) begin
            if (snap_q[l]) begin
                sum1 = sum1 + SW'(w_q[cnt_q][l]);
            end else begin
                sum0 = sum0 + SW'(w_q[cnt_q][l]);
            end
        end
    end

`ifdef SYN_TIE_HOLD_EN
    assign row_bit = (sum1 > sum0) || ((sum1 == sum0) && nin_q[cnt_q]);
`else
    assign row_bit = (sum1 > sum0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
            cnt_q  <= '0;
        end else if (snap_ld) begin
            snap_q <= bus.nout;
            cnt_q  <= '0;
        end else if (row_en && !last_row) begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Results stage in shadow so nin switches all bits in a single edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (row_en) begin
            shadow_q[cnt_q] <= row_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nin_q    <= '0;
            done_q   <= 1'b0;
            wr_rej_q <= 1'b0;
        end else begin
            if (nin_ld) begin
                nin_q <= shadow_q;
            end
            done_q   <= nin_ld;
            wr_rej_q <= wr_bad;
        end
    end

    assign bus.nin    = nin_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.wr_rej = wr_rej_q;
endmodule

// File: doc/synapse_array_seq.md
SYNAPSE_ARRAY_SEQ -- requirements
Module: synapse_array_seq

Interface
REQ-001 SHALL have parameter N, default 15, meaning neuron count (legal range 2..64).
REQ-002 SHALL have parameter WW, default 2, meaning unsigned weight width in bits (legal range 1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request one network update.
REQ-006 SHALL have port nout  input  N  neuron output vector.
REQ-007 SHALL have port w_we  input  1  weight write strobe.
REQ-008 SHALL have port w_row and port w_col  input  clog2(N) each  weight address (row k, column l).
REQ-009 SHALL have port w_data  input  WW  weight value.
REQ-010 SHALL have port nin  output  N  registered neuron input vector.
REQ-011 SHALL have port busy  output  1  high while an update is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when nin is updated.
REQ-013 SHALL have port wr_rej  output  1  one-cycle pulse when a write is dropped.

Function
REQ-014 SHALL hold an N x N weight store, one WW-bit entry per (k,l).
REQ-015 SHALL have FSM states IDLE, RUN, DONE; busy = 1 in RUN and DONE.
REQ-016 In IDLE, start = 1 SHALL capture nout into a snapshot, set the row counter to 0, and go to RUN.
REQ-017 In RUN, each cycle SHALL evaluate row k = counter over all N columns, using the snapshot only, not live nout.
REQ-018 Per row: sum1 = sum of W[k][l] where snap[l] = 1; sum0 = sum of W[k][l] where snap[l] = 0.
REQ-019 Sum registers SHALL be clog2(N*(2^WW-1)+1) bits wide, so that no overflow is possible.
REQ-020 Row result SHALL be 1 if sum1 > sum0, else 0 (tie behaviour per REQ-031/032), staged in a shadow vector.
REQ-021 When the counter reaches N-1, that row SHALL be evaluated and the FSM SHALL go to DONE; the counter SHALL never exceed N-1.
REQ-022 In DONE, nin SHALL load the full shadow vector atomically, done SHALL pulse for 1 cycle, and the FSM SHALL return to IDLE.
REQ-023 Latency: if start is sampled at edge 0, nin and done SHALL change at edge N+1, and the next start SHALL be accepted at edge N+2.
REQ-024 start while busy SHALL be ignored, with no queueing.
REQ-025 w_we in IDLE SHALL write W[w_row][w_col] <= w_data at that edge.
REQ-026 w_we while busy SHALL leave the store unchanged and pulse wr_rej the next cycle.
REQ-027 Simultaneous w_we and start in IDLE: the write SHALL commit and row 0 evaluation SHALL see the new weight.
REQ-028 A write address >= N SHALL be dropped and SHALL pulse wr_rej.
REQ-029 nin SHALL change only in DONE.

Reset
REQ-030 rst_n low, at any time including mid-RUN, SHALL immediately force:
- FSM to IDLE
- counter and snapshot to 0
- shadow vector to 0
- nin to 0
- busy, done and wr_rej to 0
- all weights to 0
An interrupted update SHALL produce no done pulse.

Configuration
REQ-031 With macro SYN_TIE_HOLD_EN defined, sum1 == sum0 SHALL keep the row's current nin bit.
REQ-032 Without SYN_TIE_HOLD_EN, sum1 == sum0 SHALL give 0.

Verification
REQ-033 Reset -> N=15, WW=2; write all 225 weights = 3; nout = 15'h7FFF; start at edge 0 -> done at edge 16, nin = 15'h7FFF.
REQ-034 Same weights; nout = 0 -> nin = 0 (sum1 = 0, sum0 = 45).
REQ-035 N=4, WW=1, all weights 1, nin previously 4'b1111, nout = 4'b0011 -> tie on every row: nin = 4'b0000 without SYN_TIE_HOLD_EN, nin = 4'b1111 with it.
REQ-036 w_we = 1 at edge 3 of a RUN, address (0,0), data 0 -> W[0][0] unchanged, wr_rej high for 1 cycle, result unaffected; start at edge 5 ignored.
REQ-037 rst_n low at edge 7 of a RUN -> busy = 0 and nin = 0 immediately, no done pulse; a fresh start afterwards completes normally in N+1 cycles.
REQ-038 Snapshot check: nout toggled every cycle during RUN -> nin matches a computation on the nout captured at start.
